// File: rtl/pipelined_bit_counter.sv
// Two-stage elastic leading/trailing zero/one counter.
// S1 preconditions the operand into a leading-zero problem and encodes nibbles; S2 picks the boundary nibble.

module pbc_nibble (
  input  logic [3:0] i_nib,
  output logic       o_zero,
  output logic [1:0] o_lz
);
  assign o_zero = ~|i_nib;

  always_comb begin
    o_lz = 2'd3;
    if (i_nib[3])      o_lz = 2'd0;
    else if (i_nib[2]) o_lz = 2'd1;
    else if (i_nib[1]) o_lz = 2'd2;
  end
endmodule

module pipelined_bit_counter #(
  parameter  int DATA_WIDTH = 32,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] operand_i,
  input  logic [1:0]            mode_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  all_match_o
);
  localparam int NIB  = DATA_WIDTH / 4;
  localparam int IDXW = CNT_WIDTH - 2;

  generate
    if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_width
      $error("pipelined_bit_counter: DATA_WIDTH must be a multiple of 4 in 8..64");
    end
  endgenerate

  logic                  r_s1_valid;
  logic [NIB-1:0]        r_s1_zero;
  logic [NIB-1:0][1:0]   r_s1_lz;
  logic                  r_valid_o;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_all_match;

  logic                  w_s2_load;
  logic                  w_s1_load;
  logic [DATA_WIDTH-1:0] w_inv;
  logic [DATA_WIDTH-1:0] w_rev;
  logic [DATA_WIDTH-1:0] w_pre;
  logic [NIB-1:0]        w_zero;
  logic [NIB-1:0][1:0]   w_lz;
  logic [IDXW-1:0]       w_idx;
  logic [1:0]            w_loc;
  logic                  w_any;
  logic [CNT_WIDTH-1:0]  w_count;

  assign w_s2_load = !r_valid_o || ready_i;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  // A flushed cycle always swallows the offered input, even when the output is stalled.
  assign ready_o   = flush_i || w_s1_load;

  // Ones modes invert, trailing modes mirror: everything becomes a leading-zero count.
  always_comb begin
    w_inv = mode_i[0] ? ~operand_i : operand_i;
    w_rev = '0;
    for (int b = 0; b < DATA_WIDTH; b++) w_rev[b] = w_inv[DATA_WIDTH-1-b];
    w_pre = mode_i[1] ? w_rev : w_inv;
  end

  generate
    for (genvar g = 0; g < NIB; g++) begin : g_nib
      pbc_nibble u_nib (
        .i_nib  (w_pre[4*g +: 4]),
        .o_zero (w_zero[g]),
        .o_lz   (w_lz[g])
      );
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (w_s1_load && valid_i) begin
      r_s1_zero <= w_zero;
      r_s1_lz   <= w_lz;
    end
  end

  // Higher nibbles are visited last, so the most significant non-zero nibble wins.
  always_comb begin
    w_idx = '0;
    w_loc = '0;
    w_any = 1'b0;
    for (int k = 0; k < NIB; k++) begin
      if (!r_s1_zero[k]) begin
        w_any = 1'b1;
        w_idx = IDXW'(NIB - 1 - k);
        w_loc = r_s1_lz[k];
      end
    end
    w_count = w_any ? {w_idx, w_loc} : CNT_WIDTH'(DATA_WIDTH);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_valid  <= 1'b0;
      r_valid_o   <= 1'b0;
      r_count     <= '0;
      r_all_match <= 1'b0;
    end else if (flush_i) begin
      r_s1_valid  <= 1'b0;
      r_valid_o   <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_valid_o <= r_s1_valid;
        if (r_s1_valid) begin
          r_count     <= w_count;
          r_all_match <= !w_any;
        end
      end
      if (w_s1_load) r_s1_valid <= valid_i;
    end
  end

  assign valid_o     = r_valid_o;
  assign count_o     = r_count;
  assign all_match_o = r_all_match;
endmodule
